// File: rtl/m_seg7_scan_if.sv
// Load channel for the 7-segment scan controller: valid/ready handshake carrying
// one hex nibble and one decimal-point bit per digit.
interface m_seg7_scan_if #(
    parameter int N_DIG = 4
);
    logic                 ld_valid;
    logic [4*N_DIG-1:0]   ld_data;
    logic [N_DIG-1:0]     ld_dp;
    logic                 ld_ready;

    modport master (output ld_valid, ld_data, ld_dp, input ld_ready);
    modport slave  (input ld_valid, ld_data, ld_dp, output ld_ready);
endinterface

// File: rtl/m_seg7_scan.sv
// Time-multiplexed scan controller for an N-digit common-anode 7-segment display
// with dark gaps between digits and tear-free loads applied at frame boundaries.
module m_seg7_scan #(
    parameter int N_DIG  = 4,
    parameter int DWELL  = 1000,
    parameter int BLANK  = 16,
    parameter int LZB_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    m_seg7_scan_if.slave     ld_if,
    output logic [N_DIG-1:0] an,
    output logic [6:0]       disp,
    output logic             dp,
    output logic             frame_done
);
    localparam int IW   = (N_DIG > 1) ? $clog2(N_DIG) : 1;
    localparam int CMAX = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic {ST_BLANK, ST_SHOW} state_t;

    state_t               r_state, w_state_next;
    logic [CW-1:0]        r_cnt, w_cnt_next;
    logic [IW-1:0]        r_idx, w_idx_next;
    logic [4*N_DIG-1:0]   r_act_data, r_shd_data;
    logic [N_DIG-1:0]     r_act_dp, r_shd_dp;
    logic                 r_pending;
    logic                 w_accept, w_wrap, w_apply, w_show, w_lz_blank;
    logic [3:0]           w_nib [N_DIG];
    logic [N_DIG-1:0]     w_nz;
    logic [3:0]           w_cur_nib;
    logic [N_DIG-1:0]     r_an;
    logic [6:0]           r_disp;
    logic                 r_dp, r_frame_done;

    function automatic logic [6:0] seg7_decode(input logic [3:0] h);
        case (h)
            4'h0: seg7_decode = 7'h40;
            4'h1: seg7_decode = 7'h79;
            4'h2: seg7_decode = 7'h24;
            4'h3: seg7_decode = 7'h30;
            4'h4: seg7_decode = 7'h19;
            4'h5: seg7_decode = 7'h12;
            4'h6: seg7_decode = 7'h02;
            4'h7: seg7_decode = 7'h78;
            4'h8: seg7_decode = 7'h00;
            4'h9: seg7_decode = 7'h18;
            4'hA: seg7_decode = 7'h08;
            4'hB: seg7_decode = 7'h03;
            4'hC: seg7_decode = 7'h46;
            4'hD: seg7_decode = 7'h21;
            4'hE: seg7_decode = 7'h06;
            default: seg7_decode = 7'h0E;
        endcase
    endfunction

    assign w_accept       = ld_if.ld_valid & ~r_pending;
    assign ld_if.ld_ready = ~r_pending;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt + 1'b1;
        w_idx_next   = r_idx;
        w_wrap       = 1'b0;
        if (!enable) begin
            w_state_next = ST_BLANK;
            w_cnt_next   = '0;
        end else begin
            case (r_state)
                ST_BLANK: begin
                    if (r_cnt == CW'(BLANK - 1)) begin
                        w_state_next = ST_SHOW;
                        w_cnt_next   = '0;
                    end
                end
                ST_SHOW: begin
                    if (r_cnt == CW'(DWELL - 1)) begin
                        w_state_next = ST_BLANK;
                        w_cnt_next   = '0;
                        if (r_idx == IW'(N_DIG - 1)) begin
                            w_idx_next = '0;
                            w_wrap     = 1'b1;
                        end else begin
                            w_idx_next = r_idx + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // While disabled the display is dark, so a pending load can land without tearing.
    assign w_apply = r_pending & (w_wrap | ~enable);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_BLANK;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_act_data <= '0;
            r_act_dp   <= '0;
            r_shd_data <= '0;
            r_shd_dp   <= '0;
            r_pending  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_idx   <= w_idx_next;
            if (w_apply) begin
                r_act_data <= r_shd_data;
                r_act_dp   <= r_shd_dp;
            end
            if (w_accept) begin
                r_shd_data <= ld_if.ld_data;
                r_shd_dp   <= ld_if.ld_dp;
            end
            r_pending <= w_accept | (r_pending & ~w_apply);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_DIG; gi++) begin : g_nib
            assign w_nib[gi] = r_act_data[4*gi +: 4];
            assign w_nz[gi]  = |r_act_data[4*gi +: 4];
        end
    endgenerate

    assign w_cur_nib  = w_nib[r_idx];
    assign w_show     = enable & (r_state == ST_SHOW);
    assign w_lz_blank = (LZB_EN != 0) && (r_idx != '0) && ((w_nz >> r_idx) == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_an         <= '1;
            r_disp       <= 7'h7F;
            r_dp         <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_an         <= w_show ? ~(N_DIG'(1) << r_idx) : '1;
            r_disp       <= (w_show & ~w_lz_blank) ? seg7_decode(w_cur_nib) : 7'h7F;
            r_dp         <= w_show ? ~r_act_dp[r_idx] : 1'b1;
            r_frame_done <= w_wrap;
        end
    end

    assign an         = r_an;
    assign disp       = r_disp;
    assign dp         = r_dp;
    assign frame_done = r_frame_done;
endmodule

// File: tb/tb_m_seg7_scan.sv
// Directed bench for m_seg7_scan: two instances (plain and leading-zero blanking)
// share clock, reset, enable and load stimulus.
module tb_m_seg7_scan;
    localparam int N_DIG = 4;
    localparam int DWELL = 4;
    localparam int BLANK = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        tb_valid;
    logic [15:0] tb_data;
    logic [3:0]  tb_dp;

    logic [3:0] an0, an1;
    logic [6:0] disp0, disp1;
    logic       dp0, dp1, fd0, fd1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    m_seg7_scan_if #(.N_DIG(N_DIG)) ld_if0 ();
    m_seg7_scan_if #(.N_DIG(N_DIG)) ld_if1 ();

    assign ld_if0.ld_valid = tb_valid;
    assign ld_if0.ld_data  = tb_data;
    assign ld_if0.ld_dp    = tb_dp;
    assign ld_if1.ld_valid = tb_valid;
    assign ld_if1.ld_data  = tb_data;
    assign ld_if1.ld_dp    = tb_dp;

    m_seg7_scan #(.N_DIG(N_DIG), .DWELL(DWELL), .BLANK(BLANK), .LZB_EN(0)) u_dut0 (
        .clk(clk), .rst(rst), .enable(enable), .ld_if(ld_if0),
        .an(an0), .disp(disp0), .dp(dp0), .frame_done(fd0)
    );

    m_seg7_scan #(.N_DIG(N_DIG), .DWELL(DWELL), .BLANK(BLANK), .LZB_EN(1)) u_dut1 (
        .clk(clk), .rst(rst), .enable(enable), .ld_if(ld_if1),
        .an(an1), .disp(disp1), .dp(dp1), .frame_done(fd1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // p is the cycle position inside a 24-cycle frame as seen on the outputs.
    task automatic check_p(input int p, input logic [15:0] d, input logic [3:0] dpv, input logic rdy);
        int         dig;
        logic [3:0] e_an;
        logic [6:0] e_d0, e_d1;
        logic       e_dp;
        logic [3:0] nib;
        dig  = p / 6;
        e_an = 4'hF;
        e_d0 = 7'h7F;
        e_d1 = 7'h7F;
        e_dp = 1'b1;
        if ((p % 6) >= 2) begin
            e_an[dig] = 1'b0;
            nib       = d[4*dig +: 4];
            e_d0      = seg_tab[nib];
            e_d1      = (dig > 0 && (d >> (4*dig)) == 16'h0) ? 7'h7F : e_d0;
            e_dp      = ~dpv[dig];
        end
        chk($sformatf("an0@p%0d", p), an0, e_an);
        chk($sformatf("disp0@p%0d", p), disp0, e_d0);
        chk($sformatf("dp0@p%0d", p), dp0, e_dp);
        chk($sformatf("fd0@p%0d", p), fd0, (p == 23));
        chk($sformatf("an1@p%0d", p), an1, e_an);
        chk($sformatf("disp1@p%0d", p), disp1, e_d1);
        chk($sformatf("dp1@p%0d", p), dp1, e_dp);
        chk($sformatf("fd1@p%0d", p), fd1, (p == 23));
        chk($sformatf("rdy0@p%0d", p), ld_if0.ld_ready, rdy);
        chk($sformatf("rdy1@p%0d", p), ld_if1.ld_ready, rdy);
    endtask

    task automatic run_span(input int p0, input int p1, input logic [15:0] d, input logic [3:0] dpv,
                            input int ld_at, input logic [15:0] ld_val, input logic [3:0] ld_dpv,
                            input int ig_at);
        for (int p = p0; p <= p1; p++) begin
            if (p == ld_at) begin
                tb_valid = 1'b1;
                tb_data  = ld_val;
                tb_dp    = ld_dpv;
                $display("[TB] load 0x%h dp %b at p=%0d", ld_val, ld_dpv, p);
            end else if (p == ig_at) begin
                tb_valid = 1'b1;
                tb_data  = 16'h5555;
                tb_dp    = 4'hF;
                $display("[TB] load 0x5555 offered while busy at p=%0d", p);
            end
            tick();
            tb_valid = 1'b0;
            check_p(p, d, dpv, !(ld_at >= 0 && p >= ld_at && p < 23));
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, " an0"}, an0, 4'hF);
        chk({tag, " disp0"}, disp0, 7'h7F);
        chk({tag, " dp0"}, dp0, 1'b1);
        chk({tag, " fd0"}, fd0, 1'b0);
        chk({tag, " rdy0"}, ld_if0.ld_ready, 1'b1);
        chk({tag, " an1"}, an1, 4'hF);
    endtask

    initial begin
        rst      = 1'b1;
        enable   = 1'b0;
        tb_valid = 1'b0;
        tb_data  = 16'h0;
        tb_dp    = 4'h0;
        tick();
        tick();
        check_reset("reset");
        rst = 1'b0;

        // Load while disabled: applied at once, so the first lit frame shows it.
        tb_valid = 1'b1;
        tb_data  = 16'h1234;
        tb_dp    = 4'h0;
        $display("[TB] load 0x1234 dp 0000 while disabled");
        tick();
        tb_valid = 1'b0;
        chk("init ready drop", ld_if0.ld_ready, 1'b0);
        tick();
        chk("init ready back", ld_if0.ld_ready, 1'b1);
        chk("init dark", an0, 4'hF);
        enable = 1'b1;

        run_span(0, 23, 16'h1234, 4'b0000, -1, 16'h0, 4'h0, -1);
        run_span(0, 23, 16'h1234, 4'b0000, 0, 16'h3210, 4'b0001, -1);
        run_span(0, 23, 16'h3210, 4'b0001, 0, 16'h7654, 4'b0010, -1);
        run_span(0, 23, 16'h7654, 4'b0010, 0, 16'hBA98, 4'b0100, -1);
        run_span(0, 23, 16'hBA98, 4'b0100, 0, 16'hFEDC, 4'b1000, -1);
        run_span(0, 23, 16'hFEDC, 4'b1000, 0, 16'h1234, 4'b0000, -1);
        run_span(0, 23, 16'h1234, 4'b0000, 8, 16'hABCD, 4'b1010, 11);
        run_span(0, 23, 16'hABCD, 4'b1010, 0, 16'h0050, 4'b0000, -1);
        run_span(0, 23, 16'h0050, 4'b0000, 0, 16'h0000, 4'b0001, -1);
        run_span(0, 23, 16'h0000, 4'b0001, 0, 16'h9876, 4'b0100, -1);

        // Disable while digit 2 is lit with a load pending.
        run_span(0, 14, 16'h9876, 4'b0100, 10, 16'h1357, 4'b0000, -1);
        enable = 1'b0;
        $display("[TB] enable dropped at digit 2");
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("dis an0 k%0d", k), an0, 4'hF);
            chk($sformatf("dis disp0 k%0d", k), disp0, 7'h7F);
            chk($sformatf("dis dp0 k%0d", k), dp0, 1'b1);
            chk($sformatf("dis fd0 k%0d", k), fd0, 1'b0);
            chk($sformatf("dis an1 k%0d", k), an1, 4'hF);
            chk($sformatf("dis rdy0 k%0d", k), ld_if0.ld_ready, 1'b1);
        end
        enable = 1'b1;
        $display("[TB] enable restored");
        run_span(12, 23, 16'h1357, 4'b0000, -1, 16'h0, 4'h0, -1);

        // Reset during SHOW with a load pending: the load must be lost.
        run_span(0, 4, 16'h1357, 4'b0000, 2, 16'h2468, 4'b1111, -1);
        rst = 1'b1;
        $display("[TB] reset asserted mid-frame");
        tick();
        check_reset("midrst");
        rst = 1'b0;
        run_span(0, 23, 16'h0000, 4'b0000, -1, 16'h0, 4'h0, -1);
        run_span(0, 23, 16'h0000, 4'b0000, -1, 16'h0, 4'h0, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
